// File: rtl/serial_tx_unit.sv
// Output stage behind the access controller: latches a memory word and sends it
// either serially MSB-first or as a single parallel beat, then pulses o_tx_done.
module serial_tx_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_parallel_load,
    input  logic                  i_tx_data,
    input  logic                  i_mode,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic                  o_sout,
    output logic                  o_sout_valid,
    output logic [DATA_WIDTH-1:0] o_pout,
    output logic                  o_pout_valid,
    output logic                  o_tx_done,
    output logic                  o_tx_busy
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADED,
        S_SHIFT,
        S_PAR,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_mode;
    logic [BW-1:0]         r_bitCnt;
    logic [CW-1:0]         r_cycCnt;

    state_t                w_stateNext;
    logic [DATA_WIDTH-1:0] w_shregNext;
    logic                  w_modeNext;
    logic [BW-1:0]         w_bitCntNext;
    logic [CW-1:0]         w_cycCntNext;

    always_comb begin
        w_stateNext  = r_state;
        w_shregNext  = r_shreg;
        w_modeNext   = r_mode;
        w_bitCntNext = r_bitCnt;
        w_cycCntNext = r_cycCnt;
        case (r_state)
            S_IDLE: begin
                if (i_parallel_load) begin
                    w_shregNext = i_din;
                    w_modeNext  = i_mode;
                    w_stateNext = S_LOADED;
                end
            end
            S_LOADED: begin
                if (i_parallel_load) begin
                    w_shregNext = i_din;
                    w_modeNext  = i_mode;
                end else if (i_tx_data) begin
                    w_stateNext  = r_mode ? S_PAR : S_SHIFT;
                    w_bitCntNext = '0;
                    w_cycCntNext = '0;
                end
            end
            S_SHIFT: begin
                // A bit advances only once it has been held for BIT_CYCLES clocks.
                if (r_cycCnt == CYC_LAST) begin
                    w_cycCntNext = '0;
                    w_shregNext  = r_shreg << 1;
                    w_bitCntNext = r_bitCnt + 1'b1;
                    if (r_bitCnt == BIT_LAST) begin
                        w_stateNext = S_DONE;
                    end
                end else begin
                    w_cycCntNext = r_cycCnt + 1'b1;
                end
            end
            S_PAR:   w_stateNext = S_DONE;
            S_DONE:  w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_mode       <= 1'b0;
            r_bitCnt     <= '0;
            r_cycCnt     <= '0;
            o_sout       <= 1'b0;
            o_sout_valid <= 1'b0;
            o_pout       <= '0;
            o_pout_valid <= 1'b0;
            o_tx_done    <= 1'b0;
            o_tx_busy    <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_shreg      <= w_shregNext;
            r_mode       <= w_modeNext;
            r_bitCnt     <= w_bitCntNext;
            r_cycCnt     <= w_cycCntNext;
            o_sout       <= (w_stateNext == S_SHIFT) ? w_shregNext[DATA_WIDTH-1] : 1'b0;
            o_sout_valid <= (w_stateNext == S_SHIFT);
            o_pout       <= (w_stateNext == S_PAR) ? w_shregNext : '0;
            o_pout_valid <= (w_stateNext == S_PAR);
            o_tx_done    <= (w_stateNext == S_DONE);
            o_tx_busy    <= (w_stateNext == S_LOADED) || (w_stateNext == S_SHIFT)
                            || (w_stateNext == S_PAR);
        end
    end

endmodule

// File: tb/tb_serial_tx_unit.sv
// Drives two serial_tx_unit instances (BIT_CYCLES 1 and 2) with identical stimulus and
// compares every cycle against a transaction-level model of the transmitter.
module tb_serial_tx_unit;

    logic       clk = 1'b0;
    logic       rstN, pl, tx, mode;
    logic [7:0] din;

    logic       sout0, sv0, pv0, done0, busy0;
    logic [7:0] pout0;
    logic       sout1, sv1, pv1, done1, busy1;
    logic [7:0] pout1;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    // Model state per instance: held word, and the transfer currently being emitted.
    int         bcOf     [2] = '{1, 2};
    bit         mLoaded  [2];
    logic [7:0] mWord    [2];
    bit         mMode    [2];
    bit         mInTx    [2];
    int         mElapsed [2];
    int         mLen     [2];
    logic [7:0] mTxWord  [2];
    bit         mTxMode  [2];

    serial_tx_unit #(.DATA_WIDTH(8), .BIT_CYCLES(1)) u_dut0 (
        .i_clk(clk), .i_reset_n(rstN), .i_parallel_load(pl), .i_tx_data(tx),
        .i_mode(mode), .i_din(din), .o_sout(sout0), .o_sout_valid(sv0),
        .o_pout(pout0), .o_pout_valid(pv0), .o_tx_done(done0), .o_tx_busy(busy0)
    );

    serial_tx_unit #(.DATA_WIDTH(8), .BIT_CYCLES(2)) u_dut1 (
        .i_clk(clk), .i_reset_n(rstN), .i_parallel_load(pl), .i_tx_data(tx),
        .i_mode(mode), .i_din(din), .o_sout(sout1), .o_sout_valid(sv1),
        .o_pout(pout1), .o_pout_valid(pv1), .o_tx_done(done1), .o_tx_busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h (busy,done,pv,pout,sv,sout)",
                     tag, cycle, obs, exp);
        end
    endtask

    // Advance one instance's model by one clock edge, given the sampled inputs.
    task automatic stepModel(input int d, input logic r, input logic l, input logic t,
                             input logic m, input logic [7:0] w);
        if (!r) begin
            mLoaded[d]  = 0;
            mWord[d]    = '0;
            mMode[d]    = 0;
            mInTx[d]    = 0;
            mElapsed[d] = 0;
        end else if (mInTx[d]) begin
            mElapsed[d]++;
            if (mElapsed[d] == mLen[d]) mInTx[d] = 0;
        end else if (l) begin
            mWord[d]   = w;
            mMode[d]   = m;
            mLoaded[d] = 1;
        end else if (t && mLoaded[d]) begin
            mLoaded[d]  = 0;
            mInTx[d]    = 1;
            mElapsed[d] = 0;
            mTxWord[d]  = mWord[d];
            mTxMode[d]  = mMode[d];
            mLen[d]     = mMode[d] ? 2 : 8 * bcOf[d] + 1;
        end
    endtask

    function automatic logic [12:0] expOut(input int d);
        logic [12:0] e;
        e = '0;
        if (mInTx[d]) begin
            if (mElapsed[d] == mLen[d] - 1) begin
                e[11] = 1'b1;
            end else begin
                e[12] = 1'b1;
                if (mTxMode[d]) begin
                    e[10]  = 1'b1;
                    e[9:2] = mTxWord[d];
                end else begin
                    e[1] = 1'b1;
                    e[0] = mTxWord[d][7 - mElapsed[d] / bcOf[d]];
                end
            end
        end else begin
            e[12] = mLoaded[d];
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input logic l, input logic t,
                                 input logic m, input logic [7:0] w);
        rstN = r;
        pl   = l;
        tx   = t;
        mode = m;
        din  = w;
        @(posedge clk);
        cycle++;
        stepModel(0, r, l, t, m, w);
        stepModel(1, r, l, t, m, w);
        #1;
        checkOutput("dut0_bc1", {busy0, done0, pv0, pout0, sv0, sout0}, expOut(0));
        checkOutput("dut1_bc2", {busy1, done1, pv1, pout1, sv1, sout1}, expOut(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 8'h00);
    endtask

    initial begin
        rstN = 0; pl = 0; tx = 0; mode = 0; din = '0;
        for (int d = 0; d < 2; d++) begin
            mLoaded[d] = 0; mWord[d] = '0; mMode[d] = 0; mInTx[d] = 0;
            mElapsed[d] = 0; mLen[d] = 0; mTxWord[d] = '0; mTxMode[d] = 0;
        end
        @(negedge clk);

        // Reset held two cycles, then released
        applyStimulus(0, 0, 0, 0, 8'h00);
        applyStimulus(0, 1, 1, 1, 8'hFF);
        idle(2);

        // Serial A5
        applyStimulus(1, 1, 0, 0, 8'hA5);
        applyStimulus(1, 0, 1, 0, 8'h00);
        idle(20);

        // Parallel 3C
        applyStimulus(1, 1, 0, 1, 8'h3C);
        applyStimulus(1, 0, 1, 0, 8'h00);
        idle(4);

        // Serial 81 with a load attempted mid-shift
        applyStimulus(1, 1, 0, 0, 8'h81);
        applyStimulus(1, 0, 1, 0, 8'h00);
        idle(4);
        applyStimulus(1, 1, 0, 0, 8'hFF);
        applyStimulus(1, 0, 1, 1, 8'hFF);
        idle(16);

        // Load and start together in IDLE, then reload with start high
        applyStimulus(1, 1, 1, 0, 8'h55);
        applyStimulus(1, 1, 1, 0, 8'h0F);
        applyStimulus(1, 0, 1, 0, 8'h00);
        idle(20);

        // Reset in the middle of a serial transfer, then a fresh transfer
        applyStimulus(1, 1, 0, 0, 8'hF0);
        applyStimulus(1, 0, 1, 0, 8'h00);
        idle(4);
        applyStimulus(0, 0, 0, 0, 8'h00);
        idle(2);
        applyStimulus(1, 1, 0, 0, 8'h96);
        applyStimulus(1, 0, 1, 0, 8'h00);
        idle(20);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(63) != 0),
                          ($urandom_range(3) == 0),
                          ($urandom_range(2) == 0),
                          1'($urandom_range(1)),
                          8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
